lcd_fb_sched: RTL and testbench
===============================

# lcd_fb_sched

Frame-buffer read scheduler between the SDRAM read port and the LCD driver. It turns the driver's per-word `lcd_rden` pulls into SDRAM burst reads, prefetching into a local FIFO. Each `lcd_framesync` restarts the fetch at the active frame-buffer base, and a bank-select request switches between two frame buffers only on a frame boundary.

## Interface
- `H_WORDS`, 120: 96-bit words per line (4 px × 24 bit per word).
- `V_LINES`, 272: lines per frame.
- `BURST_LEN`, 8: words per SDRAM burst. `H_WORDS*V_LINES` must be a multiple of it; elaboration fails otherwise.
- `FIFO_DEPTH`, 32: prefetch FIFO depth in words, power of 2, ≥ 2·BURST_LEN.
- `ADDR_W`, 24: SDRAM word-address width.
- `FB_BASE0`, 0: word address of frame buffer 0.
- `FB_BASE1`, 24'h010000: word address of frame buffer 1.

Ports:
- `clk_lcd`  in  1  LCD-domain clock; the only clock.
- `lcd_rst_n`  in  1  asynchronous, active-low reset.
- `bank_toggle`  in  1  single-cycle pulse (debounced key); requests a buffer switch.
- `lcd_framesync`  in  1  single-cycle pulse at the start of vertical blanking.
- `lcd_rden`  in  1  driver pulls one word.
- `lcd_data`  out  96  word returned for `lcd_rden`.
- `rd_req`  out  1  burst request to SDRAM.
- `rd_addr`  out  ADDR_W  burst start address.
- `rd_ack`  in  1  SDRAM accepted the request.
- `rd_valid`  in  1  read-data beat strobe.
- `rd_data`  in  96  read-data beat.
- `bank_sel`  out  1  frame buffer currently being scanned.
- `underflow`  out  1  sticky flag: a pull arrived while the FIFO was empty.

## Operation
- FSM states: IDLE, FLUSH, FILL, REQ, DATA, DONE.
- **IDLE** (after reset): waits for `lcd_framesync`, then goes to FLUSH.
- **FLUSH** (one cycle):
  - clears the FIFO;
  - applies a pending bank toggle to `bank_sel`;
  - loads the address pointer with `FB_BASE[bank_sel]` (using the new `bank_sel`);
  - zeroes the burst counter and clears `underflow`;
  - goes to FILL.
- **FILL**:
  - if all `H_WORDS*V_LINES/BURST_LEN` bursts have been issued, go to DONE;
  - else if FIFO free slots ≥ BURST_LEN, go to REQ.
- **REQ**: asserts `rd_req` with `rd_addr` = pointer. On `rd_ack`: pointer += BURST_LEN, burst counter +1, go to DATA.
- **DATA**: writes each `rd_valid` beat into the FIFO. After exactly BURST_LEN beats, go to FILL. At most one burst is ever outstanding, so the FIFO cannot overflow.
- **DONE**: waits for `lcd_framesync`, then goes to FLUSH.
- `lcd_framesync` in FILL or IDLE: go to FLUSH.
- `lcd_framesync` in REQ or DATA:
  - sets a restart flag;
  - REQ: keep `rd_req` held until `rd_ack` (no withdrawal once raised);
  - then drain the outstanding BURST_LEN beats and discard them (not written to the FIFO);
  - then go to FLUSH.
- `bank_toggle` sets `bank_pend`. A second toggle before the frame boundary clears it. `bank_pend` is consumed in FLUSH.
- `lcd_rden` with the FIFO non-empty pops one word.
- `lcd_rden` with the FIFO empty: sets `underflow`, and `lcd_data` repeats its previous value.
- FIFO push and pop in the same cycle: level is unchanged.
- Address arithmetic is modulo 2^ADDR_W; wrap is permitted and not flagged.

## Timing
- Reset values:
  - `rd_req` = 0, `rd_addr` = 0;
  - `lcd_data` = 0;
  - `bank_sel` = 0, `bank_pend` = 0;
  - `underflow` = 0;
  - FIFO empty, FSM in IDLE.
- `lcd_data` is registered and valid the cycle after `lcd_rden`.
- `rd_req` rises one cycle after FILL decides to fetch. It stays high with `rd_addr` stable until the cycle `rd_ack` = 1, and drops the following cycle.
- `rd_valid` beats may come with gaps, no earlier than the cycle after `rd_ack`.
- A `rd_valid` beat written in cycle N can be popped from cycle N+1.
- Latency from `lcd_framesync` in FILL to the first `rd_req` is 3 cycles (FLUSH, FILL, REQ).
- Reset asserted mid-burst: state is abandoned immediately. Late `rd_valid` beats arriving after reset is released are ignored, because they arrive outside the DATA state.

## Structure
- Package `lcd_fb_pkg` holds:
  - the FSM state enum;
  - `FRAME_WORDS` = H_WORDS*V_LINES;
  - `FRAME_BURSTS` = FRAME_WORDS/BURST_LEN;
  - the burst-counter width, computed with `$clog2`.
- Sub-module `lcd_fb_fifo`: synchronous FIFO, 96-bit wide, FIFO_DEPTH deep, registered read, with level output and clear input. The scheduler FSM and counters stay in the top.

## Test plan
Bench parameters: H_WORDS=4, V_LINES=2, BURST_LEN=4, FIFO_DEPTH=16, FB_BASE1=24'h100.
- **Cold frame:** reset, then `lcd_framesync`, SDRAM model acks after 2 cycles.
  - Required: bursts at addresses 0 then 4, then DONE.
  - With the driver pulling 8 words, `lcd_data` returns model data words 0–7 in order; `underflow` stays 0.
- **Back-pressure:** FIFO_DEPTH=8, driver idle after framesync.
  - Required: exactly 2 bursts issued (8 words buffered), `rd_req` stays low until a pull frees 4 slots, then burst 3 is issued.
- **Bank switch:** `bank_toggle` pulsed mid-frame.
  - Required: `bank_sel` stays 0 until the next framesync; then the first `rd_addr` is 0x100 and `bank_sel` = 1.
  - Two pulses within one frame leave `bank_sel` unchanged.
- **Framesync during DATA** after 2 of 4 beats:
  - Required: the remaining 2 beats are discarded, the FIFO is cleared, and the next `rd_req` is at the bank base.
- **Underflow:** `lcd_rden` with the FIFO empty.
  - Required: `underflow` = 1 and `lcd_data` holds its last value; the next framesync clears `underflow`.
- **Async reset mid-REQ:**
  - Required: `rd_req` falls in the same cycle `lcd_rst_n` falls; all outputs take their reset values.

Source files
------------

// File: rtl/lcd_fb_pkg.sv
// Shared types and sizing helpers for the LCD frame-buffer read scheduler.
package lcd_fb_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLUSH,
    S_FILL,
    S_REQ,
    S_DATA,
    S_DONE
  } state_e;

  localparam int unsigned WORD_W        = 96;
  localparam int unsigned H_WORDS_DEF   = 120;
  localparam int unsigned V_LINES_DEF   = 272;
  localparam int unsigned BURST_LEN_DEF = 8;

  localparam int unsigned FRAME_WORDS  = H_WORDS_DEF * V_LINES_DEF;
  localparam int unsigned FRAME_BURSTS = FRAME_WORDS / BURST_LEN_DEF;
  localparam int unsigned BCNT_W       = $clog2(FRAME_BURSTS + 1);

  // Same quantities for instances that override the default geometry.
  function automatic int unsigned frame_words(input int unsigned h, input int unsigned v);
    return h * v;
  endfunction

  function automatic int unsigned frame_bursts(input int unsigned words, input int unsigned burst);
    return words / burst;
  endfunction

  function automatic int unsigned bcnt_width(input int unsigned bursts);
    return $clog2(bursts + 1);
  endfunction

endpackage

// File: rtl/lcd_fb_fifo.sv
// Prefetch FIFO: registered read port, synchronous clear, occupancy output.
module lcd_fb_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !clr && (count != LW'(DEPTH));
  assign do_pop  = pop && !clr && (count != '0);
  assign level   = count;
  assign empty   = (count == '0);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // rdata only moves on a successful pop, so an empty pull repeats the last word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      rdata  <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        rdata  <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/lcd_fb_sched.sv
// Frame-buffer read scheduler: turns LCD word pulls into SDRAM burst reads
// through a prefetch FIFO, restarting at the active buffer base on each framesync.
module lcd_fb_sched
  import lcd_fb_pkg::*;
#(
  parameter int unsigned       H_WORDS    = H_WORDS_DEF,
  parameter int unsigned       V_LINES    = V_LINES_DEF,
  parameter int unsigned       BURST_LEN  = BURST_LEN_DEF,
  parameter int unsigned       FIFO_DEPTH = 32,
  parameter int unsigned       ADDR_W     = 24,
  parameter logic [ADDR_W-1:0] FB_BASE0   = '0,
  parameter logic [ADDR_W-1:0] FB_BASE1   = ADDR_W'(24'h010000)
) (
  input  logic              clk_lcd,
  input  logic              lcd_rst_n,
  input  logic              bank_toggle,
  input  logic              lcd_framesync,
  input  logic              lcd_rden,
  output logic [WORD_W-1:0] lcd_data,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_valid,
  input  logic [WORD_W-1:0] rd_data,
  output logic              bank_sel,
  output logic              underflow,
  output state_e            dbg_state
);

  localparam int unsigned N_WORDS   = frame_words(H_WORDS, V_LINES);
  localparam int unsigned N_BURSTS  = frame_bursts(N_WORDS, BURST_LEN);
  localparam int unsigned BCNT_BITS = bcnt_width(N_BURSTS);
  localparam int unsigned BEAT_BITS = $clog2(BURST_LEN + 1);
  localparam int unsigned LVL_BITS  = $clog2(FIFO_DEPTH + 1);

  if (N_WORDS % BURST_LEN != 0) begin : g_bad_burst
    $error("lcd_fb_sched: H_WORDS*V_LINES must be a multiple of BURST_LEN");
  end
  if ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || FIFO_DEPTH < 2 * BURST_LEN) begin : g_bad_fifo
    $error("lcd_fb_sched: FIFO_DEPTH must be a power of 2 and at least 2*BURST_LEN");
  end

  state_e                state;
  logic [ADDR_W-1:0]     ptr;
  logic [BCNT_BITS-1:0]  bcnt;
  logic [BEAT_BITS-1:0]  beat;
  logic                  restart;
  logic                  bank_pend;
  logic                  bank_next;
  logic [LVL_BITS-1:0]   fifo_level;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_clr;
  logic                  fifo_room;

  assign bank_next = bank_sel ^ bank_pend;
  assign fifo_clr  = (state == S_FLUSH);
  // Beats drained after a mid-burst framesync belong to the abandoned frame.
  assign fifo_push = (state == S_DATA) && rd_valid && !restart;
  assign fifo_room = (32'(fifo_level) + BURST_LEN) <= FIFO_DEPTH;
  assign dbg_state = state;

  lcd_fb_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk_lcd),
    .rst_n (lcd_rst_n),
    .clr   (fifo_clr),
    .push  (fifo_push),
    .wdata (rd_data),
    .pop   (lcd_rden),
    .rdata (lcd_data),
    .level (fifo_level),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk_lcd or negedge lcd_rst_n) begin
    if (!lcd_rst_n) begin
      state     <= S_IDLE;
      ptr       <= '0;
      bcnt      <= '0;
      beat      <= '0;
      restart   <= 1'b0;
      bank_sel  <= 1'b0;
      bank_pend <= 1'b0;
      rd_req    <= 1'b0;
      rd_addr   <= '0;
      underflow <= 1'b0;
    end else begin
      if (state == S_FLUSH)  bank_pend <= bank_toggle;
      else if (bank_toggle)  bank_pend <= ~bank_pend;

      if (lcd_rden && fifo_empty) underflow <= 1'b1;

      case (state)
        S_IDLE, S_DONE: begin
          if (lcd_framesync) state <= S_FLUSH;
        end
        S_FLUSH: begin
          bank_sel  <= bank_next;
          ptr       <= bank_next ? FB_BASE1 : FB_BASE0;
          bcnt      <= '0;
          beat      <= '0;
          restart   <= 1'b0;
          underflow <= 1'b0;
          state     <= S_FILL;
        end
        S_FILL: begin
          if (lcd_framesync) begin
            state <= S_FLUSH;
          end else if (bcnt == BCNT_BITS'(N_BURSTS)) begin
            state <= S_DONE;
          end else if (fifo_room) begin
            rd_req  <= 1'b1;
            rd_addr <= ptr;
            state   <= S_REQ;
          end
        end
        // A raised request is never withdrawn; a framesync only marks the burst for discard.
        S_REQ: begin
          if (lcd_framesync) restart <= 1'b1;
          if (rd_ack) begin
            rd_req <= 1'b0;
            ptr    <= ptr + ADDR_W'(BURST_LEN);
            bcnt   <= bcnt + 1'b1;
            beat   <= '0;
            state  <= S_DATA;
          end
        end
        S_DATA: begin
          if (lcd_framesync) restart <= 1'b1;
          if (rd_valid) begin
            if (beat == BEAT_BITS'(BURST_LEN - 1)) begin
              beat  <= '0;
              state <= (restart || lcd_framesync) ? S_FLUSH : S_FILL;
            end else begin
              beat <= beat + 1'b1;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_fb_sched.sv
// Self-checking bench for lcd_fb_sched: SDRAM model, per-scenario tests, scoreboard queues.
module tb_lcd_fb_sched;
  import lcd_fb_pkg::*;

  localparam int unsigned BL = 4;
  localparam int unsigned FW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        bank_toggle, framesync, rden;
  logic [95:0] lcd_data;
  logic        rd_req;
  logic [23:0] rd_addr;
  logic        rd_ack, rd_valid;
  logic [95:0] rd_data;
  logic        bank_sel, underflow;
  state_e      state;

  logic        bp_toggle, bp_framesync, bp_rden;
  logic [95:0] bp_data;
  logic        bp_req;
  logic [23:0] bp_addr;
  logic        bp_ack, bp_valid;
  logic [95:0] bp_rdata;
  logic        bp_bank_sel, bp_underflow;
  state_e      bp_state;

  int checks = 0;
  int errors = 0;
  int ack_dly = 2;
  int beat_gap = 0;
  int beats_sent = 0;

  logic [95:0] exp_q[$];
  logic [23:0] exp_addr_q[$];
  logic [23:0] got_addr_q[$];

  lcd_fb_sched #(
    .H_WORDS(4), .V_LINES(2), .BURST_LEN(BL), .FIFO_DEPTH(16),
    .ADDR_W(24), .FB_BASE0(24'h0), .FB_BASE1(24'h100)
  ) u_dut (
    .clk_lcd(clk), .lcd_rst_n(rst_n), .bank_toggle(bank_toggle),
    .lcd_framesync(framesync), .lcd_rden(rden), .lcd_data(lcd_data),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_valid(rd_valid),
    .rd_data(rd_data), .bank_sel(bank_sel), .underflow(underflow), .dbg_state(state)
  );

  lcd_fb_sched #(
    .H_WORDS(4), .V_LINES(4), .BURST_LEN(BL), .FIFO_DEPTH(8),
    .ADDR_W(24), .FB_BASE0(24'h0), .FB_BASE1(24'h100)
  ) u_bp (
    .clk_lcd(clk), .lcd_rst_n(rst_n), .bank_toggle(bp_toggle),
    .lcd_framesync(bp_framesync), .lcd_rden(bp_rden), .lcd_data(bp_data),
    .rd_req(bp_req), .rd_addr(bp_addr), .rd_ack(bp_ack), .rd_valid(bp_valid),
    .rd_data(bp_rdata), .bank_sel(bp_bank_sel), .underflow(bp_underflow), .dbg_state(bp_state)
  );

  function automatic logic [95:0] model_word(input logic [23:0] a);
    return {8'hA5, 40'h0, ~a, a};
  endfunction

  // SDRAM model for u_dut: acks after ack_dly cycles, then BL beats spaced by beat_gap.
  initial begin
    logic [23:0] m_addr;
    rd_ack = 1'b0; rd_valid = 1'b0; rd_data = '0;
    forever begin
      @(negedge clk);
      if (rst_n && rd_req) begin
        m_addr = rd_addr;
        for (int k = 1; k < ack_dly && rst_n; k++) @(negedge clk);
        if (!rst_n) continue;
        rd_ack = 1'b1;
        got_addr_q.push_back(m_addr);
        @(negedge clk);
        rd_ack = 1'b0;
        for (int b = 0; b < int'(BL); b++) begin
          if (!rst_n) break;
          rd_valid = 1'b1;
          rd_data = model_word(m_addr + 24'(b));
          beats_sent++;
          @(negedge clk);
          rd_valid = 1'b0;
          for (int k = 0; k < beat_gap; k++) @(negedge clk);
        end
        rd_valid = 1'b0;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not reach its summary");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_framesync();
    framesync = 1'b1;
    tick();
    framesync = 1'b0;
  endtask

  task automatic expect_frame(input logic [23:0] base);
    for (int i = 0; i < 2; i++) exp_addr_q.push_back(base + 24'(BL * i));
    for (int i = 0; i < int'(FW); i++) exp_q.push_back(model_word(base + 24'(i)));
  endtask

  task automatic wait_done(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (state == S_DONE) begin ok = 1'b1; return; end
      tick();
    end
  endtask

  task automatic bp_serve(output logic ok, output logic [23:0] a);
    ok = 1'b0; a = '0;
    for (int k = 0; k < 50; k++) begin
      if (bp_req) begin ok = 1'b1; break; end
      tick();
    end
    if (!ok) return;
    a = bp_addr;
    bp_ack = 1'b1;
    tick();
    bp_ack = 1'b0;
    for (int b = 0; b < int'(BL); b++) begin
      bp_valid = 1'b1;
      bp_rdata = model_word(a + 24'(b));
      tick();
    end
    bp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bank_toggle = 0; framesync = 0; rden = 0;
    bp_toggle = 0; bp_framesync = 0; bp_rden = 0; bp_ack = 0; bp_valid = 0; bp_rdata = '0;
    repeat (3) tick();
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b expected 0", rd_req); end
    checks++; if (rd_addr !== 24'h0) begin errors++; $display("FAIL reset_rd_addr: got %h expected 0", rd_addr); end
    checks++; if (lcd_data !== 96'h0) begin errors++; $display("FAIL reset_lcd_data: got %h expected 0", lcd_data); end
    checks++; if (bank_sel !== 1'b0) begin errors++; $display("FAIL reset_bank_sel: got %b expected 0", bank_sel); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %b expected 0", underflow); end
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", int'(state), int'(S_IDLE)); end
    rst_n = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_cold_frame();
    logic ok;
    logic [23:0] ea, ga;
    logic [95:0] ew;
    expect_frame(24'h0);
    pulse_framesync();
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL cold_done: got state %0d expected DONE", int'(state)); end
    while (exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front();
      ga = (got_addr_q.size() > 0) ? got_addr_q.pop_front() : 24'hxxxxxx;
      checks++; if (ga !== ea) begin errors++; $display("FAIL cold_addr: got %h expected %h", ga, ea); end
    end
    checks++; if (got_addr_q.size() != 0) begin errors++; $display("FAIL cold_extra_bursts: got %0d expected 0", got_addr_q.size()); end
    rden = 1'b1;
    for (int i = 0; i < int'(FW); i++) begin
      tick();
      ew = exp_q.pop_front();
      checks++; if (lcd_data !== ew) begin errors++; $display("FAIL cold_data[%0d]: got %h expected %h", i, lcd_data, ew); end
    end
    rden = 1'b0;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL cold_underflow: got %b expected 0", underflow); end
  endtask

  task automatic test_underflow();
    logic ok;
    logic [23:0] ea, ga;
    logic [95:0] ew;
    rden = 1'b1;
    tick();
    rden = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL uf_set: got %b expected 1", underflow); end
    tick();
    checks++; if (lcd_data !== model_word(24'h7)) begin errors++; $display("FAIL uf_hold: got %h expected %h", lcd_data, model_word(24'h7)); end
    expect_frame(24'h0);
    pulse_framesync();
    tick();
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL uf_clear: got %b expected 0", underflow); end
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL uf_done: got state %0d expected DONE", int'(state)); end
    while (exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front();
      ga = (got_addr_q.size() > 0) ? got_addr_q.pop_front() : 24'hxxxxxx;
      checks++; if (ga !== ea) begin errors++; $display("FAIL uf_addr: got %h expected %h", ga, ea); end
    end
    rden = 1'b1;
    for (int i = 0; i < int'(FW); i++) begin
      tick();
      ew = exp_q.pop_front();
      checks++; if (lcd_data !== ew) begin errors++; $display("FAIL uf_data[%0d]: got %h expected %h", i, lcd_data, ew); end
    end
    rden = 1'b0;
  endtask

  task automatic test_bank_switch();
    logic ok;
    logic [23:0] ea, ga;
    logic [95:0] ew;
    logic [23:0] bases [3];
    logic        exp_bank [3];
    bases[0] = 24'h0;   exp_bank[0] = 1'b0;
    bases[1] = 24'h100; exp_bank[1] = 1'b1;
    bases[2] = 24'h100; exp_bank[2] = 1'b1;
    for (int f = 0; f < 3; f++) begin
      expect_frame(bases[f]);
      pulse_framesync();
      tick();
      checks++; if (bank_sel !== exp_bank[f]) begin errors++; $display("FAIL bank_sel[%0d]: got %b expected %b", f, bank_sel, exp_bank[f]); end
      tick();
      // One toggle in frame 0 (switch pending), two in frame 1 (cancel out).
      if (f < 2) begin bank_toggle = 1'b1; tick(); bank_toggle = 1'b0; end
      if (f == 1) begin tick(); bank_toggle = 1'b1; tick(); bank_toggle = 1'b0; end
      repeat (2) tick();
      checks++; if (bank_sel !== exp_bank[f]) begin errors++; $display("FAIL bank_hold[%0d]: got %b expected %b", f, bank_sel, exp_bank[f]); end
      wait_done(ok);
      checks++; if (!ok) begin errors++; $display("FAIL bank_done[%0d]: got state %0d expected DONE", f, int'(state)); end
      while (exp_addr_q.size() > 0) begin
        ea = exp_addr_q.pop_front();
        ga = (got_addr_q.size() > 0) ? got_addr_q.pop_front() : 24'hxxxxxx;
        checks++; if (ga !== ea) begin errors++; $display("FAIL bank_addr[%0d]: got %h expected %h", f, ga, ea); end
      end
      rden = 1'b1;
      for (int i = 0; i < int'(FW); i++) begin
        tick();
        ew = exp_q.pop_front();
        checks++; if (lcd_data !== ew) begin errors++; $display("FAIL bank_data[%0d][%0d]: got %h expected %h", f, i, lcd_data, ew); end
      end
      rden = 1'b0;
    end
  endtask

  task automatic test_sync_in_data();
    logic ok;
    logic [23:0] ea, ga;
    logic [95:0] ew;
    int start;
    beat_gap = 3;
    start = beats_sent;
    exp_addr_q.push_back(24'h100);
    pulse_framesync();
    ok = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (beats_sent >= start + 2) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL sync_two_beats: got %0d beats expected 2", beats_sent - start); end
    expect_frame(24'h100);
    pulse_framesync();
    beat_gap = 0;
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL sync_done: got state %0d expected DONE", int'(state)); end
    while (exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front();
      ga = (got_addr_q.size() > 0) ? got_addr_q.pop_front() : 24'hxxxxxx;
      checks++; if (ga !== ea) begin errors++; $display("FAIL sync_addr: got %h expected %h", ga, ea); end
    end
    rden = 1'b1;
    for (int i = 0; i < int'(FW); i++) begin
      tick();
      ew = exp_q.pop_front();
      checks++; if (lcd_data !== ew) begin errors++; $display("FAIL sync_data[%0d]: got %h expected %h", i, lcd_data, ew); end
    end
    rden = 1'b0;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL sync_underflow: got %b expected 0", underflow); end
  endtask

  task automatic test_back_pressure();
    logic ok, saw;
    logic [23:0] a;
    logic [95:0] ew;
    for (int i = 0; i < 16; i++) exp_q.push_back(model_word(24'(i)));
    bp_framesync = 1'b1; tick(); bp_framesync = 1'b0;
    for (int b = 0; b < 2; b++) begin
      bp_serve(ok, a);
      checks++; if (!ok || a !== 24'(BL * b)) begin errors++; $display("FAIL bp_burst[%0d]: got ok=%b addr %h expected addr %h", b, ok, a, 24'(BL * b)); end
    end
    saw = 1'b0;
    for (int k = 0; k < 20; k++) begin tick(); if (bp_req) saw = 1'b1; end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL bp_full_no_req: got req %b expected 0", saw); end
    checks++; if (bp_state !== S_FILL) begin errors++; $display("FAIL bp_state: got %0d expected %0d", int'(bp_state), int'(S_FILL)); end
    bp_rden = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      ew = exp_q.pop_front();
      checks++; if (bp_data !== ew) begin errors++; $display("FAIL bp_data[%0d]: got %h expected %h", i, bp_data, ew); end
    end
    bp_rden = 1'b0;
    saw = 1'b0;
    for (int k = 0; k < 10; k++) begin tick(); if (bp_req) saw = 1'b1; end
    checks++; if (saw !== 1'b0) begin errors++; $display("FAIL bp_three_free_no_req: got req %b expected 0", saw); end
    bp_rden = 1'b1;
    tick();
    bp_rden = 1'b0;
    ew = exp_q.pop_front();
    checks++; if (bp_data !== ew) begin errors++; $display("FAIL bp_data[3]: got %h expected %h", bp_data, ew); end
    bp_serve(ok, a);
    checks++; if (!ok || a !== 24'h8) begin errors++; $display("FAIL bp_burst[2]: got ok=%b addr %h expected addr 000008", ok, a); end
    checks++; if (bp_underflow !== 1'b0 || bp_bank_sel !== 1'b0) begin errors++; $display("FAIL bp_flags: got uf=%b bank=%b expected 0 0", bp_underflow, bp_bank_sel); end
    exp_q.delete();
  endtask

  task automatic test_reset_mid_req();
    logic ok;
    logic [23:0] ea, ga;
    ack_dly = 50;
    pulse_framesync();
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (rd_req) begin ok = 1'b1; break; end
      tick();
    end
    checks++; if (!ok) begin errors++; $display("FAIL rst_req_seen: got rd_req %b expected 1", rd_req); end
    rst_n = 1'b0;
    #1;
    checks++; if (rd_req !== 1'b0) begin errors++; $display("FAIL rst_rd_req: got %b expected 0", rd_req); end
    checks++; if (rd_addr !== 24'h0) begin errors++; $display("FAIL rst_rd_addr: got %h expected 0", rd_addr); end
    checks++; if (lcd_data !== 96'h0) begin errors++; $display("FAIL rst_lcd_data: got %h expected 0", lcd_data); end
    checks++; if (bank_sel !== 1'b0) begin errors++; $display("FAIL rst_bank_sel: got %b expected 0", bank_sel); end
    checks++; if (state !== S_IDLE) begin errors++; $display("FAIL rst_state: got %0d expected %0d", int'(state), int'(S_IDLE)); end
    repeat (2) tick();
    rst_n = 1'b1;
    ack_dly = 2;
    repeat (2) tick();
    got_addr_q.delete();
    expect_frame(24'h0);
    pulse_framesync();
    wait_done(ok);
    checks++; if (!ok) begin errors++; $display("FAIL rst_done: got state %0d expected DONE", int'(state)); end
    while (exp_addr_q.size() > 0) begin
      ea = exp_addr_q.pop_front();
      ga = (got_addr_q.size() > 0) ? got_addr_q.pop_front() : 24'hxxxxxx;
      checks++; if (ga !== ea) begin errors++; $display("FAIL rst_addr: got %h expected %h", ga, ea); end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_cold_frame();
    test_underflow();
    test_bank_switch();
    test_sync_in_data();
    test_back_pressure();
    test_reset_mid_req();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
